// File: rtl/world_map_writer_pkg.sv
// Shared constants for the 128x128 world-map RAM; the VGA scaler imports the same
// package so both RAM ports agree on the {row, col} address layout.
package world_map_writer_pkg;

  localparam int COORD_W = 7;
  localparam int ADDR_W  = 2 * COORD_W;
  localparam int DATA_W  = 2;

  localparam logic [DATA_W-1:0] MAP_BG    = 2'b00;
  localparam logic [DATA_W-1:0] MAP_LINE  = 2'b01;
  localparam logic [DATA_W-1:0] MAP_OBST  = 2'b10;
  localparam logic [DATA_W-1:0] MAP_TRAIL = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/world_map_writer_if.sv
// Update handshake, clear control and RAM port-B write bus of the map writer.
interface world_map_writer_if;
  import world_map_writer_pkg::*;

  logic               clear_req;
  logic               upd_valid;
  logic               upd_ready;
  logic [COORD_W-1:0] upd_row;
  logic [COORD_W-1:0] upd_col;
  logic [DATA_W-1:0]  upd_data;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               busy;
  logic               clear_done;

  modport master (
    output clear_req, upd_valid, upd_row, upd_col, upd_data,
    input  upd_ready, wr_en, wr_addr, wr_data, busy, clear_done
  );

  modport slave (
    input  clear_req, upd_valid, upd_row, upd_col, upd_data,
    output upd_ready, wr_en, wr_addr, wr_data, busy, clear_done
  );

endinterface

// File: rtl/map_clear_counter.sv
// Address counter for the full-map clear sweep; last flags the final cell.
module map_clear_counter
  import world_map_writer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              clr,
  output logic [ADDR_W-1:0] cnt,
  output logic              last
);

  always_ff @(posedge clk) begin
    if (!reset_n || clr) cnt <= '0;
    else if (en)         cnt <= cnt + 1'b1;
  end

  assign last = &cnt;

endmodule

// File: rtl/world_map_writer.sv
// Write-side port of the world-map RAM: registered update writes with duplicate
// suppression, plus a one-write-per-cycle full-map clear sweep.
//
// state    | meaning
// ST_IDLE  | accepting updates, clear_req starts a sweep
// ST_CLEAR | sweeping every address with CLEAR_VAL, updates stalled
module world_map_writer
  import world_map_writer_pkg::*;
#(
  parameter logic [DATA_W-1:0] CLEAR_VAL      = MAP_BG,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input logic               clk,
  input logic               reset_n,
  world_map_writer_if.slave bus
);

  state_t                   state, state_nxt;
  logic [ADDR_W-1:0]        cnt;
  logic                     cnt_last;
  logic                     cnt_en;
  logic                     enter_clear;
  logic                     accept;
  logic                     dup;
  logic [ADDR_W-1:0]        upd_addr;
  logic [ADDR_W+DATA_W-1:0] last_pair;
  logic                     last_vld;

  assign upd_addr = {bus.upd_row, bus.upd_col};
  assign dup      = last_vld && (last_pair == {upd_addr, bus.upd_data});

  map_clear_counter u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (cnt_en),
    .clr     (enter_clear),
    .cnt     (cnt),
    .last    (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.clear_req) state_nxt = ST_CLEAR;
      ST_CLEAR: if (cnt_last)      state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.upd_ready = 1'b0;
    bus.busy      = 1'b0;
    cnt_en        = 1'b0;
    enter_clear   = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.upd_ready = ~bus.clear_req;
        enter_clear   = bus.clear_req;
      end
      ST_CLEAR: begin
        bus.busy = 1'b1;
        cnt_en   = 1'b1;
      end
      default: ;
    endcase
    accept = bus.upd_valid & bus.upd_ready;
  end

  // A suppressed duplicate is still consumed; it simply produces no write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.clear_done <= 1'b0;
      last_pair      <= '0;
      last_vld       <= 1'b0;
    end else begin
      bus.wr_en      <= 1'b0;
      bus.clear_done <= (state == ST_CLEAR) && cnt_last;
      if (state == ST_CLEAR) begin
        bus.wr_en   <= 1'b1;
        bus.wr_addr <= cnt;
        bus.wr_data <= CLEAR_VAL;
      end else if (accept && !dup) begin
        bus.wr_en   <= 1'b1;
        bus.wr_addr <= upd_addr;
        bus.wr_data <= bus.upd_data;
        last_pair   <= {upd_addr, bus.upd_data};
        last_vld    <= 1'b1;
      end
      if (enter_clear) last_vld <= 1'b0;
    end
  end

endmodule
